// File: rtl/spi_rx_deser.sv
// Receive deserializer for the SPI master: captures MISO on sample strobes, MSB- or LSB-first,
// right-justified output with valid/ready handshake and sticky overrun. Optional parity: SPI_RX_PARITY_EN.
module spi_rx_deser #(
    parameter int MAX_LEN = 128,
    parameter int LEN_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               abort,
    input  logic [LEN_W-1:0]   char_len,
    input  logic               lsb,
    input  logic               sample_en,
    input  logic               miso,
    output logic               busy,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_done,
    output logic               overrun,
    input  logic               clr_overrun,
    output logic               parity_err
);

    // One extra bit so the counter can hold MAX_LEN itself (parity slot, length clamp).
    localparam int CNT_W = LEN_W + 1;
    localparam int IDX_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_k;
    logic               r_lsb;
    logic [MAX_LEN-1:0] r_sreg;

    logic [MAX_LEN-1:0] r_rx_data;
    logic               r_rx_valid;
    logic               r_rx_done;
    logic               r_overrun;

    logic [CNT_W-1:0]   w_len_eff;
    logic               w_start;
    logic               w_fire;
    logic               w_last;
    logic               w_data_bit;
    logic               w_load;

    assign w_start = (r_state == ST_IDLE) && go;
    assign w_fire  = (r_state == ST_SHIFT) && sample_en && !abort;
    assign w_load  = (r_state == ST_DONE) && !abort;

    // char_len of zero means a full-width character; oversize requests saturate.
    always_comb begin
        w_len_eff = {1'b0, char_len};
        if ((char_len == '0) || ({1'b0, char_len} > CNT_W'(MAX_LEN))) begin
            w_len_eff = CNT_W'(MAX_LEN);
        end
    end

`ifdef SPI_RX_PARITY_EN
    logic r_par;
    // Bit index N is the parity slot; only indices below N carry data.
    assign w_data_bit = (r_k != r_len);
    assign w_last     = (r_k == r_len);
`else
    assign w_data_bit = 1'b1;
    assign w_last     = (r_k == (r_len - CNT_W'(1)));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (sample_en && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg <= '0;
            r_k    <= '0;
            r_len  <= '0;
            r_lsb  <= 1'b0;
`ifdef SPI_RX_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else if (w_start) begin
            r_sreg <= '0;
            r_k    <= '0;
            r_len  <= w_len_eff;
            r_lsb  <= lsb;
        end else if (w_fire) begin
            r_k <= r_k + CNT_W'(1);
            if (w_data_bit) begin
                if (r_lsb) begin
                    r_sreg[r_k[IDX_W-1:0]] <= miso;
                end else begin
                    r_sreg <= {r_sreg[MAX_LEN-2:0], miso};
                end
            end
`ifdef SPI_RX_PARITY_EN
            else begin
                r_par <= miso;
            end
`endif
        end
    end

    // Output side: a load always wins over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_done  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_rx_done <= w_load;
            if (w_load) begin
                r_rx_data  <= r_sreg;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_load && r_rx_valid && !rx_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_PARITY_EN
    logic r_parity_err;
    // Bits above N are always zero, so reducing the whole register is equivalent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= (^r_sreg) ^ r_par;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign busy     = (r_state != ST_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_done  = r_rx_done;
    assign overrun  = r_overrun;

endmodule
